// File: rtl/ahb_defs.sv
// Shared AHB encodings and small helpers used by the round-robin arbiter.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  typedef enum logic [1:0] {
    ST_DEFAULT = 2'd0,
    ST_OWN     = 2'd1,
    ST_BURST   = 2'd2,
    ST_LOCK    = 2'd3
  } arb_state_e;

  // Number of beats in a fixed-length burst; undefined-length INCR counts as one.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   burst_len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

  // Index of the set bit in a one-hot vector (zero when the vector is empty).
  function automatic logic [3:0] onehot_idx(input logic [15:0] oh);
    onehot_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) onehot_idx = onehot_idx | 4'(i);
    end
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module ahb_arb_rr_pick #(
  parameter int NUM_MST = 4
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [3:0]         ptr,
  output logic [NUM_MST-1:0] gnt,
  output logic               valid
);

  logic [4:0]           shamt;
  logic [NUM_MST-1:0]   req_rot;
  logic [NUM_MST-1:0]   gnt_rot;
  logic [2*NUM_MST-1:0] gnt_dbl;

  // Rotate so ptr+1 lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    shamt   = {1'b0, ptr} + 5'd1;
    req_rot = NUM_MST'({req, req} >> shamt);
    gnt_rot = req_rot & (-req_rot);
    gnt_dbl = {{NUM_MST{1'b0}}, gnt_rot} << shamt;
    gnt     = gnt_dbl[NUM_MST-1:0] | gnt_dbl[2*NUM_MST-1:NUM_MST];
    valid   = |req;
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter: registered one-hot grant, address-phase owner and
// lock tracking, with a beat counter so fixed-length bursts are never split.
module ahb_arbiter_rr
  import ahb_defs::*;
#(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0
) (
  input  logic               HRESETn,
  input  logic               HCLK,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [1:0]         HRESP,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [3:0]         HMASTER,
  output logic               HMASTLOCK
);

  localparam logic [NUM_MST-1:0] DEF_GNT = NUM_MST'(1) << DEFAULT_MST;
  localparam logic [3:0]         DEF_IDX = 4'(DEFAULT_MST);

  logic [NUM_MST-1:0] hgrant_q, hgrant_d;
  logic [3:0]         hmaster_q, hmaster_d;
  logic               hmastlock_q, hmastlock_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [3:0]         rr_ptr_q, rr_ptr_d;
  arb_state_e         state_q, state_d;

  logic [3:0]         owner_idx;
  logic               owner_req;
  logic               owner_lock;
  logic               lock_cond;
  logic               arb_ok;
  logic [NUM_MST-1:0] req_others;
  logic [NUM_MST-1:0] pick_gnt;
  logic               pick_valid;

  // Error responses need no special handling: the following IDLE re-arbitrates.
  logic hresp_unused;
  assign hresp_unused = ^HRESP;

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  // Current grant holder and its request/lock inputs.
  always_comb begin
    owner_idx  = onehot_idx(16'(hgrant_q));
    owner_req  = |(HBUSREQ & hgrant_q);
    owner_lock = |(HLOCK & hgrant_q);
    lock_cond  = owner_lock | hmastlock_q;
    req_others = HBUSREQ & ~hgrant_q;
  end

  // Beats remaining in the current fixed-length burst.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (HREADY) begin
      case (HTRANS)
        HTRANS_IDLE:   beat_cnt_d = 4'd0;
        HTRANS_NONSEQ: beat_cnt_d = 4'(burst_len(HBURST) - 5'd1);
        HTRANS_SEQ:    beat_cnt_d = (beat_cnt_q == 4'd0) ? 4'd0 : beat_cnt_q - 4'd1;
        default:       beat_cnt_d = beat_cnt_q;
      endcase
    end
  end

  // Re-arbitration point: bus idle, last beat of a burst, undefined-length
  // burst, or an owner that has withdrawn its request -- never while locked.
  always_comb begin
    arb_ok = 1'b0;
    if (HREADY && !lock_cond) begin
      if (HTRANS == HTRANS_IDLE)
        arb_ok = 1'b1;
      else if ((HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && beat_cnt_d == 4'd0)
        arb_ok = 1'b1;
      else if (HBURST == HBURST_INCR && HTRANS != HTRANS_BUSY)
        arb_ok = 1'b1;
      else if (!owner_req && HTRANS != HTRANS_SEQ && HTRANS != HTRANS_BUSY)
        arb_ok = 1'b1;
    end
  end

  // The owner is excluded from the scan, so it only keeps the bus when alone.
  ahb_arb_rr_pick #(
    .NUM_MST (NUM_MST)
  ) u_pick (
    .req   (req_others),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Next grant, round-robin pointer and address-phase ownership.
  always_comb begin
    hgrant_d    = hgrant_q;
    rr_ptr_d    = rr_ptr_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (arb_ok) begin
      if (pick_valid) begin
        hgrant_d = pick_gnt;
        rr_ptr_d = onehot_idx(16'(pick_gnt));
      end else if (owner_req) begin
        rr_ptr_d = owner_idx;
      end else begin
        hgrant_d = DEF_GNT;
      end
    end
    if (HREADY) begin
      hmaster_d   = owner_idx;
      hmastlock_d = owner_lock;
    end
  end

  // Arbiter state: a locked sequence is only left through a re-arbitration point.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOCK && !arb_ok)
      state_d = ST_LOCK;
    else if (hmastlock_d || (|(HLOCK & hgrant_d)))
      state_d = ST_LOCK;
    else if (beat_cnt_d != 4'd0)
      state_d = ST_BURST;
    else if (hgrant_d == DEF_GNT && !(|HBUSREQ))
      state_d = ST_DEFAULT;
    else
      state_d = ST_OWN;
  end

  // State registers; reset returns the bus to the default master at once.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hgrant_q    <= DEF_GNT;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= 4'd0;
      rr_ptr_q    <= DEF_IDX;
      state_q     <= ST_DEFAULT;
    end else begin
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr: directed scenarios followed by a
// randomized run, all compared against a behavioural arbiter model.
module tb_ahb_arbiter_rr;

  localparam int N   = 4;
  localparam int DEF = 0;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic         HRESETn;
  logic         HCLK;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [N-1:0] HGRANT;
  logic [3:0]   HMASTER;
  logic         HMASTLOCK;

  int errors = 0;
  int checks = 0;

  ahb_arbiter_rr #(
    .NUM_MST     (N),
    .DEFAULT_MST (DEF)
  ) dut (
    .HRESETn   (HRESETn),
    .HCLK      (HCLK),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural model: owner/pointer kept as plain integers.
  int m_grant, m_master, m_ptr, m_cnt;
  bit m_mlock;
  int nx_grant, nx_master, nx_ptr, nx_cnt;
  bit nx_mlock;
  int beats_of [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic model_reset();
    m_grant  = DEF;
    m_master = DEF;
    m_ptr    = DEF;
    m_cnt    = 0;
    m_mlock  = 1'b0;
  endtask

  task automatic model_compute();
    int  owner, win, i;
    bit  own_req, own_lock, reason, ok;
    owner    = m_grant;
    own_req  = HBUSREQ[owner];
    own_lock = HLOCK[owner];
    nx_cnt   = m_cnt;
    if (HREADY) begin
      if (HTRANS == T_IDLE)        nx_cnt = 0;
      else if (HTRANS == T_NONSEQ) nx_cnt = beats_of[HBURST] - 1;
      else if (HTRANS == T_SEQ)    nx_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    end
    reason = (HTRANS == T_IDLE)
          || (HTRANS >= T_NONSEQ && nx_cnt == 0)
          || (HBURST == 3'd1 && HTRANS != 2'd1)
          || (!own_req && HTRANS != T_SEQ && HTRANS != 2'd1);
    ok = HREADY && !(own_lock || m_mlock) && reason;
    nx_grant = m_grant;
    nx_ptr   = m_ptr;
    if (ok) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        i = (m_ptr + k) % N;
        if (win < 0 && i != owner && HBUSREQ[i]) win = i;
      end
      if (win < 0 && own_req) win = owner;
      if (win >= 0) begin
        nx_grant = win;
        nx_ptr   = win;
      end else begin
        nx_grant = DEF;
      end
    end
    nx_master = HREADY ? owner : m_master;
    nx_mlock  = HREADY ? own_lock : m_mlock;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".grant"},  32'(HGRANT),    32'(1) << m_grant);
    check({tag, ".master"}, 32'(HMASTER),   32'(m_master));
    check({tag, ".lock"},   32'(HMASTLOCK), 32'(m_mlock));
  endtask

  // One bus clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick(input string tag);
    model_compute();
    @(posedge HCLK);
    #1;
    m_grant  = nx_grant;
    m_master = nx_master;
    m_ptr    = nx_ptr;
    m_cnt    = nx_cnt;
    m_mlock  = nx_mlock;
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge.
  task automatic do_reset();
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = T_IDLE;
    HBURST  = B_SINGLE;
    HREADY  = 1'b1;
    HRESP   = 2'd0;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    int exp_order [5] = '{1, 2, 3, 0, 1};

    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = T_IDLE;
    HBURST  = B_SINGLE;
    HREADY  = 1'b1;
    HRESP   = 2'd0;
    model_reset();
    #12;
    check("por.grant",  32'(HGRANT),    32'h1);
    check("por.master", 32'(HMASTER),   32'h0);
    check("por.lock",   32'(HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Round-robin over four always-requesting masters doing singles.
    do_reset();
    HBUSREQ = 4'b1111;
    HTRANS  = T_NONSEQ;
    HBURST  = B_SINGLE;
    for (int s = 0; s < 5; s++) begin
      tick("rr");
      check("rr_order", 32'(HGRANT), 32'(1) << exp_order[s]);
    end

    // INCR4 by M1 with a two-cycle stall on beat 2 while M2 waits.
    do_reset();
    HBUSREQ = 4'b0010;
    tick("burst_gnt");
    check("burst_gnt_m1", 32'(HGRANT), 32'h2);
    tick("burst_own");
    check("burst_master_m1", 32'(HMASTER), 32'h1);
    HBUSREQ = 4'b0110;
    HTRANS  = T_NONSEQ;
    HBURST  = B_INCR4;
    tick("burst_b1");
    HTRANS = T_SEQ;
    HREADY = 1'b0;
    tick("burst_stall");
    tick("burst_stall");
    check("burst_hold_stall", 32'(HGRANT), 32'h2);
    HREADY = 1'b1;
    tick("burst_b2");
    tick("burst_b3");
    check("burst_hold_b3", 32'(HGRANT), 32'h2);
    tick("burst_b4");
    check("burst_handover_m2", 32'(HGRANT), 32'h4);

    // Locked singles by M3 keep M0 out until one phase after HMASTLOCK drops.
    do_reset();
    HBUSREQ = 4'b1000;
    HLOCK   = 4'b1000;
    tick("lock_gnt");
    tick("lock_own");
    check("lock_mastlock_set", 32'(HMASTLOCK), 32'h1);
    HBUSREQ = 4'b1001;
    HTRANS  = T_NONSEQ;
    for (int s = 0; s < 3; s++) begin
      tick("lock_single");
      check("lock_hold", 32'(HGRANT), 32'h8);
    end
    HLOCK   = 4'b0000;
    HBUSREQ = 4'b0001;
    HTRANS  = T_IDLE;
    tick("lock_trail");
    check("lock_mastlock_drop", 32'(HMASTLOCK), 32'h0);
    check("lock_trail_hold", 32'(HGRANT), 32'h8);
    tick("lock_release");
    check("lock_m0_granted", 32'(HGRANT), 32'h1);

    // Idle bus returns grant to default; pointer remembers M2.
    do_reset();
    HBUSREQ = 4'b0100;
    tick("idle_gnt");
    tick("idle_own");
    HBUSREQ = 4'b0000;
    HTRANS  = T_NONSEQ;
    tick("idle_last");
    check("idle_default", 32'(HGRANT), 32'h1);
    HTRANS  = T_IDLE;
    HBUSREQ = 4'b1011;
    tick("idle_ptr");
    check("idle_ptr_m3_next", 32'(HGRANT), 32'h8);

    // Asynchronous reset during beat 5 of a locked INCR8.
    do_reset();
    HBUSREQ = 4'b0010;
    HLOCK   = 4'b0010;
    tick("ar_gnt");
    tick("ar_own");
    HTRANS = T_NONSEQ;
    HBURST = B_INCR8;
    tick("ar_b1");
    HTRANS = T_SEQ;
    for (int s = 0; s < 3; s++) tick("ar_beat");
    check("ar_pre_master", 32'(HMASTER), 32'h1);
    check("ar_pre_lock", 32'(HMASTLOCK), 32'h1);
    #3;
    HRESETn = 1'b0;
    #1;
    model_reset();
    check("ar_grant", 32'(HGRANT), 32'h1);
    check("ar_master", 32'(HMASTER), 32'h0);
    check("ar_lock", 32'(HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = T_IDLE;

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        HBUSREQ = N'($urandom);
        HLOCK   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
        HTRANS  = 2'($urandom);
        HBURST  = 3'($urandom);
        HREADY  = ($urandom_range(0, 3) != 0);
        HRESP   = 2'($urandom_range(0, 1));
        tick("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
